// File: rtl/opb_mst_pkg.sv
// Shared types and constants for the single-beat OPB master: FSM states, response codes, widths.
package opb_mst_pkg;

    localparam int unsigned OpbAwidth = 32;
    localparam int unsigned OpbDwidth = 32;
    localparam int unsigned RspErrW   = 2;

    localparam logic [RspErrW-1:0] RspOk      = 2'b00;
    localparam logic [RspErrW-1:0] RspErrAck  = 2'b01;
    localparam logic [RspErrW-1:0] RspTimeout = 2'b10;
    localparam logic [RspErrW-1:0] RspRetry   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StXfer,
        StBackoff
    } opb_mst_state_e;

endpackage

// File: rtl/opb_single_beat_master.sv
// Fabric-to-OPB initiator: one accepted command becomes one single-beat OPB transfer plus a response.
// Define OPB_MST_RETRY_EN to re-issue after OPB_retry (with backoff) instead of failing at once.
module opb_single_beat_master
    import opb_mst_pkg::*;
#(
    parameter int unsigned C_OPB_AWIDTH = OpbAwidth,
    parameter int unsigned C_OPB_DWIDTH = OpbDwidth,
    parameter int unsigned C_MAX_RETRY  = 4,
    parameter int unsigned C_BACKOFF    = 2
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
    input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
    input  logic [C_OPB_DWIDTH-1:0]     cmd_data,

    output logic                        rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]     rsp_data,
    output logic [RspErrW-1:0]          rsp_err,

    output logic                        M_request,
    output logic                        M_select,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    output logic                        M_RNW,
    output logic                        M_busLock,
    output logic                        M_seqAddr,

    input  logic                        OPB_MGrant,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_timeout,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
);

    localparam int unsigned BeW = C_OPB_DWIDTH / 8;

    // Parameter sanity; the retry bound also keeps the counter width reasonable.
    if (C_BACKOFF < 1 || (C_OPB_DWIDTH % 8) != 0 || C_MAX_RETRY > 1024) begin : g_cfg_check
        $error("opb_single_beat_master: illegal parameter combination");
    end

    opb_mst_state_e state_q, state_d;

    logic                    rnw_q, rnw_d;
    logic [C_OPB_AWIDTH-1:0] addr_q, addr_d;
    logic [BeW-1:0]          be_q, be_d;
    logic [C_OPB_DWIDTH-1:0] data_q, data_d;

    logic                    rsp_valid_q, rsp_valid_d;
    logic [C_OPB_DWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [RspErrW-1:0]      rsp_err_q, rsp_err_d;

    logic                    accept;
    logic                    term_valid;
    logic [RspErrW-1:0]      term_err;

    assign accept = cmd_valid & cmd_ready;

`ifdef OPB_MST_RETRY_EN
    localparam int unsigned RetryW   = (C_MAX_RETRY < 1) ? 1 : $clog2(C_MAX_RETRY + 1);
    localparam int unsigned BackoffW = (C_BACKOFF <= 1) ? 1 : $clog2(C_BACKOFF);

    logic [RetryW-1:0]   retry_cnt_q, retry_cnt_d;
    logic [BackoffW-1:0] backoff_cnt_q, backoff_cnt_d;
    logic                reissue;
    logic                backoff_done;

    assign backoff_done = (backoff_cnt_q == BackoffW'(C_BACKOFF - 1));

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (accept) begin
            retry_cnt_d = '0;
        end else if (reissue) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
        end
    end

    // Counts cycles spent in BACKOFF; parked at zero everywhere else.
    always_comb begin
        backoff_cnt_d = '0;
        if (state_q == StBackoff && !backoff_done) begin
            backoff_cnt_d = backoff_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            retry_cnt_q   <= '0;
            backoff_cnt_q <= '0;
        end else begin
            retry_cnt_q   <= retry_cnt_d;
            backoff_cnt_q <= backoff_cnt_d;
        end
    end
`endif

    // Terminator decode for the XFER state: errAck > timeout > xferAck > retry.
    always_comb begin
        term_valid = 1'b0;
        term_err   = RspOk;
`ifdef OPB_MST_RETRY_EN
        reissue    = 1'b0;
`endif
        if (state_q == StXfer) begin
            if (OPB_errAck) begin
                term_valid = 1'b1;
                term_err   = RspErrAck;
            end else if (OPB_timeout) begin
                term_valid = 1'b1;
                term_err   = RspTimeout;
            end else if (OPB_xferAck) begin
                term_valid = 1'b1;
                term_err   = RspOk;
            end else if (OPB_retry) begin
`ifdef OPB_MST_RETRY_EN
                if (retry_cnt_q == RetryW'(C_MAX_RETRY)) begin
                    term_valid = 1'b1;
                    term_err   = RspRetry;
                end else begin
                    reissue = 1'b1;
                end
`else
                term_valid = 1'b1;
                term_err   = RspRetry;
`endif
            end
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StArb;
            end
            StArb: begin
                if (OPB_MGrant) state_d = StXfer;
            end
            StXfer: begin
                if (term_valid) begin
                    state_d = StIdle;
`ifdef OPB_MST_RETRY_EN
                end else if (reissue) begin
                    state_d = StBackoff;
`endif
                end
            end
`ifdef OPB_MST_RETRY_EN
            StBackoff: begin
                if (backoff_done) state_d = StArb;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Command is frozen from accept until the response is issued.
    always_comb begin
        rnw_d  = rnw_q;
        addr_d = addr_q;
        be_d   = be_q;
        data_d = data_q;
        if (accept) begin
            rnw_d  = cmd_rnw;
            addr_d = cmd_addr;
            be_d   = cmd_be;
            data_d = cmd_data;
        end
    end

    // Response fields are zero except in the single rsp_valid cycle.
    always_comb begin
        rsp_valid_d = term_valid;
        rsp_err_d   = term_valid ? term_err : RspOk;
        rsp_data_d  = '0;
        if (term_valid && term_err == RspOk && rnw_q) begin
            rsp_data_d = OPB_DBus;
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= RspOk;
        end else begin
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Bus outputs are zero outside the address phase so they can be OR-ed onto the OPB.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        M_request = (state_q == StArb);
        M_select  = (state_q == StXfer);
        M_RNW     = M_select & rnw_q;
        M_ABus    = M_select ? addr_q : '0;
        M_BE      = M_select ? be_q : '0;
        M_DBus    = (M_select && !rnw_q) ? data_q : '0;
        M_busLock = 1'b0;
        M_seqAddr = 1'b0;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
    end

endmodule
